serializer: RTL and testbench
=============================

# serializer

SPI-style frame transmitter: accepts one instruction word (opcode, key address, text address) per valid/ready handshake and shifts it out MSB-first on `mosi`. It generates `spi_clk` and `cs_n` itself. It is the master-side counterpart of `deserializer`, which samples `mosi` on `spi_clk` rising edges while `cs_n` is low. The block sits in the host/test harness and drives the control block's instruction port.

## Interface
- `ADDRW`, 8, width of key and text address fields
- `OPCODEW`, 2, opcode width; frame width `SHIFT_W = OPCODEW + 2*ADDRW` (18 by default)
- `CLK_DIV`, 3, `clk` cycles per `spi_clk` half-period (≥1)
- `GAP_CYCLES`, 8, minimum `clk` cycles `cs_n` stays high between frames (≥1)

Ports:
- `clk`  in  1  system clock; everything is synchronous to its rising edge
- `rst`  in  1  synchronous reset, active-high
- `opcode`  in  OPCODEW  frame bits [SHIFT_W-1 : SHIFT_W-OPCODEW]
- `key_addr`  in  ADDRW  next ADDRW bits
- `text_addr`  in  ADDRW  bits [ADDRW-1:0]
- `valid_in`  in  1  input word valid
- `ready_out`  out  1  high only in IDLE; transfer occurs on `valid_in && ready_out`
- `abort`  in  1  request to terminate the current frame
- `spi_clk`  out  1  serial clock, idles low (mode 0)
- `mosi`  out  1  serial data
- `cs_n`  out  1  chip select, active-low
- `done`  out  1  one-cycle pulse when a complete frame ends
- `aborted`  out  1  one-cycle pulse when a frame is cut short

## Operation
- States: IDLE, SETUP, HIGH, LOW, HOLD, GAP. A divider counter `div_cnt` (0..CLK_DIV-1) and a bit counter `bit_cnt` (0..SHIFT_W-1) advance the state machine.
- **Reset.** While `rst` is high: state=IDLE, `cs_n`=1, `spi_clk`=0, `mosi`=0, `done`=0, `aborted`=0, counters=0. `ready_out`=1 (it is decoded from state). Handshakes are ignored during reset. A reset mid-frame takes effect on the next edge: `cs_n` rises immediately with no gap, and there is no `done` or `aborted` pulse.
- **IDLE → SETUP** on accept:
  - latch `{opcode,key_addr,text_addr}` into the shift register
  - `cs_n`←0, `mosi`←frame MSB, `ready_out`→0
- **SETUP.** Lasts CLK_DIV cycles with `spi_clk`=0, then moves to HIGH with `spi_clk`←1.
- **HIGH.** Lasts CLK_DIV cycles.
  - If this was the last bit (`bit_cnt`=SHIFT_W-1): `spi_clk`←0, go to HOLD.
  - Otherwise: `spi_clk`←0, shift so `mosi`←next bit, `bit_cnt`+1, go to LOW.
- **LOW.** Lasts CLK_DIV cycles, then `spi_clk`←1 and go to HIGH.
- `mosi` changes only on the same edge where `spi_clk` falls (or on the SETUP entry edge). It is stable for the whole HIGH phase.
- **HOLD.** Lasts CLK_DIV cycles with `spi_clk`=0 and `cs_n`=0. On exit: `cs_n`←1, `mosi`←0, `done`←1 for one cycle, go to GAP.
- **GAP.** Lasts GAP_CYCLES cycles with `cs_n`=1, then go to IDLE.
- **Abort.** `abort` sampled high in SETUP, HIGH or LOW causes, on that edge: `cs_n`←1, `spi_clk`←0, `mosi`←0, `aborted`←1 for one cycle, go to GAP.
  - `abort` is ignored in IDLE, HOLD (all bits already delivered) and GAP.
  - `valid_in` and `abort` together in IDLE: the word is accepted and `abort` is ignored.
- `valid_in` while not IDLE is ignored; the input word is not consumed.
- The latched frame is unaffected by input changes after accept.

## Timing
- Accept at edge E0. `cs_n` falls at E0. The first `spi_clk` rise is at E0+CLK_DIV.
- The k-th `spi_clk` rise (k = 0..SHIFT_W-1) is at E0 + (2k+1)·CLK_DIV.
- `cs_n` rises and `done`=1 at E0 + (2·SHIFT_W+1)·CLK_DIV. With defaults this is E0+111.
- `ready_out` returns to 1 at E0 + (2·SHIFT_W+1)·CLK_DIV + GAP_CYCLES. With defaults this is E0+119.
- Abort sampled at edge Ea: `cs_n`=1 at Ea; `ready_out`=1 at Ea+GAP_CYCLES.
- Back-to-back throughput, defaults: one frame per 119 cycles plus 1 accept cycle if `valid_in` is held.
- All outputs are registered except `ready_out`, which is decoded from state.

## Test plan
- Reset, then send opcode=01, key=AA, text=55 with defaults. Required response:
  - the bits sampled on `spi_clk` rises are 01_10101010_01010101
  - exactly 18 rises occur while `cs_n`=0
  - `done` at accept+111, `ready_out` at accept+119
  - a `deserializer` instance attached to the outputs produces one `valid_out` carrying 01/AA/55
- Hold `valid_in` with 10/0F/F0 then 11/5A/C3. Required response:
  - two frames, accepted 120 cycles apart
  - `cs_n` high for 8 cycles between frames
  - the second frame carries 11/5A/C3
- Pulse `abort` during the 9th HIGH phase of 01/AA/55. Required response:
  - `cs_n` rises on the same edge, `aborted` pulses, no `done` pulse
  - exactly 9 `spi_clk` rises occurred
  - `ready_out` returns 8 cycles later; the receiver emits no `valid_out`
- Pulse `abort` during HOLD, and separately during IDLE alongside `valid_in`. Required response:
  - HOLD case: frame completes with `done`, no `aborted` pulse
  - IDLE case: the word is accepted and transmitted normally
- Assert `rst` for 1 cycle in the middle of a frame. Required response:
  - next edge: `cs_n`=1, `spi_clk`=0, `mosi`=0, `ready_out`=1
  - no `done` or `aborted` pulse
  - a subsequent frame transmits correctly
- Change the input fields and toggle `valid_in` while busy. Required response: the transmitted bits match the word latched at accept, and no extra frame is sent.

Source files
------------

// File: rtl/serializer_if.sv
// Instruction-word handshake between the host side and the serializer.
interface serializer_if #(
  parameter int unsigned ADDRW   = 8,
  parameter int unsigned OPCODEW = 2
);
  logic [OPCODEW-1:0] opcode;
  logic [ADDRW-1:0]   key_addr;
  logic [ADDRW-1:0]   text_addr;
  logic               valid_in;
  logic               ready_out;

  modport master (
    output opcode, key_addr, text_addr, valid_in,
    input  ready_out
  );

  modport slave (
    input  opcode, key_addr, text_addr, valid_in,
    output ready_out
  );
endinterface

// File: rtl/serializer.sv
// SPI mode-0 frame transmitter: shifts {opcode,key_addr,text_addr} out MSB-first
// with self-generated spi_clk/cs_n, inter-frame gap and abort support.
module serializer #(
  parameter int unsigned ADDRW      = 8,
  parameter int unsigned OPCODEW    = 2,
  parameter int unsigned CLK_DIV    = 3,
  parameter int unsigned GAP_CYCLES = 8
) (
  input  logic         clk,
  input  logic         rst,
  serializer_if.slave  bus,
  input  logic         abort,
  output logic         spi_clk,
  output logic         mosi,
  output logic         cs_n,
  output logic         done,
  output logic         aborted
);

  localparam int unsigned SHIFT_W = OPCODEW + 2 * ADDRW;
  localparam int unsigned CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned BIT_W   = $clog2(SHIFT_W);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   div_cnt, div_cnt_d;
  logic [BIT_W-1:0]   bit_cnt, bit_cnt_d;
  // Holds the bits still to be sent; the current bit already sits on mosi.
  logic [SHIFT_W-2:0] shreg, shreg_d;
  logic               spi_clk_d, mosi_d, cs_n_d, done_d, aborted_d;
  logic [SHIFT_W-1:0] frame;
  logic               phase_end, gap_end, last_bit;

  assign frame         = {bus.opcode, bus.key_addr, bus.text_addr};
  assign phase_end     = (div_cnt == CNT_W'(CLK_DIV - 1));
  assign gap_end       = (div_cnt == CNT_W'(GAP_CYCLES - 1));
  assign last_bit      = (bit_cnt == BIT_W'(SHIFT_W - 1));
  assign bus.ready_out = (state == IDLE);

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      spi_clk <= 1'b0;
      mosi    <= 1'b0;
      cs_n    <= 1'b1;
      done    <= 1'b0;
      aborted <= 1'b0;
    end else begin
      state   <= state_d;
      div_cnt <= div_cnt_d;
      bit_cnt <= bit_cnt_d;
      shreg   <= shreg_d;
      spi_clk <= spi_clk_d;
      mosi    <= mosi_d;
      cs_n    <= cs_n_d;
      done    <= done_d;
      aborted <= aborted_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state;
    div_cnt_d = div_cnt;
    bit_cnt_d = bit_cnt;
    shreg_d   = shreg;
    spi_clk_d = spi_clk;
    mosi_d    = mosi;
    cs_n_d    = cs_n;
    done_d    = 1'b0;
    aborted_d = 1'b0;

    case (state)
      IDLE: begin
        if (bus.valid_in) begin
          state_d   = SETUP;
          shreg_d   = frame[SHIFT_W-2:0];
          mosi_d    = frame[SHIFT_W-1];
          cs_n_d    = 1'b0;
          div_cnt_d = '0;
          bit_cnt_d = '0;
        end
      end

      SETUP, HIGH, LOW: begin
        if (abort) begin
          state_d   = GAP;
          cs_n_d    = 1'b1;
          spi_clk_d = 1'b0;
          mosi_d    = 1'b0;
          aborted_d = 1'b1;
          div_cnt_d = '0;
        end else if (!phase_end) begin
          div_cnt_d = div_cnt + CNT_W'(1);
        end else begin
          div_cnt_d = '0;
          if (state == HIGH) begin
            spi_clk_d = 1'b0;
            if (last_bit) begin
              state_d = HOLD;
            end else begin
              state_d   = LOW;
              mosi_d    = shreg[SHIFT_W-2];
              shreg_d   = {shreg[SHIFT_W-3:0], 1'b0};
              bit_cnt_d = bit_cnt + BIT_W'(1);
            end
          end else begin
            state_d   = HIGH;
            spi_clk_d = 1'b1;
          end
        end
      end

      HOLD: begin
        if (phase_end) begin
          state_d   = GAP;
          cs_n_d    = 1'b1;
          mosi_d    = 1'b0;
          done_d    = 1'b1;
          div_cnt_d = '0;
        end else begin
          div_cnt_d = div_cnt + CNT_W'(1);
        end
      end

      GAP: begin
        if (gap_end) begin
          state_d   = IDLE;
          div_cnt_d = '0;
        end else begin
          div_cnt_d = div_cnt + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_serializer.sv
// Directed self-checking bench for serializer with default parameters; a
// negedge monitor plays the receiving deserializer.
module tb_serializer;

  localparam int unsigned SHIFT_W = 18;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic abort = 1'b0;
  logic spi_clk, mosi, cs_n, done, aborted;

  serializer_if #(.ADDRW(8), .OPCODEW(2)) bus ();

  serializer #(.ADDRW(8), .OPCODEW(2), .CLK_DIV(3), .GAP_CYCLES(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .abort   (abort),
    .spi_clk (spi_clk),
    .mosi    (mosi),
    .cs_n    (cs_n),
    .done    (done),
    .aborted (aborted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Receiver model and event recorder, sampled mid-cycle.
  int acc_cnt = 0, done_cnt = 0, abort_cnt = 0;
  int rise_cnt = 0, last_rise_cnt = 0, high_run = 0, last_high_run = 0;
  int done_edge = 0, ready_edge = 0;
  int acc_edge_q[$];
  logic [SHIFT_W-1:0] rx_sh = '0;
  logic [SHIFT_W-1:0] rx_q[$];
  bit spi_prev = 1'b0, cs_prev = 1'b1, ready_prev = 1'b1;

  always @(negedge clk) begin
    if (bus.valid_in && bus.ready_out && !rst) begin
      acc_cnt++;
      acc_edge_q.push_back(cyc + 1);
    end
    if (done) begin
      done_cnt++;
      done_edge = cyc;
    end
    if (aborted) abort_cnt++;
    if (bus.ready_out && !ready_prev) ready_edge = cyc;
    if (!cs_n && cs_prev) begin
      rise_cnt = 0;
      last_high_run = high_run;
    end
    if (cs_n && !cs_prev) begin
      last_rise_cnt = rise_cnt;
      if (rise_cnt == SHIFT_W) rx_q.push_back(rx_sh);
      high_run = 0;
    end
    if (cs_n) high_run++;
    if (!cs_n && spi_clk && !spi_prev) begin
      rx_sh = {rx_sh[SHIFT_W-2:0], mosi};
      rise_cnt++;
    end
    spi_prev   = spi_clk;
    cs_prev    = cs_n;
    ready_prev = bus.ready_out;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_word(input logic [1:0] op, input logic [7:0] k, input logic [7:0] t);
    bus.opcode    = op;
    bus.key_addr  = k;
    bus.text_addr = t;
  endtask

  task automatic wait_ready(output bit ok);
    for (int i = 0; i < 400; i++) begin
      if (bus.ready_out) break;
      tick(1);
    end
    ok = bus.ready_out;
  endtask

  function automatic logic [SHIFT_W-1:0] last_rx();
    return (rx_q.size() > 0) ? rx_q[$] : '0;
  endfunction

  task automatic test_reset();
    set_word(2'b11, 8'hFF, 8'hFF);
    bus.valid_in = 1'b1;
    tick(3);
    checks++;
    if ({cs_n, spi_clk, mosi, done, aborted} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 10000", {cs_n, spi_clk, mosi, done, aborted});
    end
    checks++;
    if (bus.ready_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 1", bus.ready_out);
    end
    bus.valid_in = 1'b0;
    rst = 1'b0;
    tick(2);
    checks++;
    if (acc_cnt !== 0 || cs_n !== 1'b1) begin
      errors++;
      $display("FAIL reset_no_accept: accepts %0d cs_n %b expected 0 and 1", acc_cnt, cs_n);
    end
  endtask

  task automatic test_basic();
    int a0, d0, f0;
    bit ok;
    a0 = acc_cnt; d0 = done_cnt; f0 = rx_q.size();
    set_word(2'b01, 8'hAA, 8'h55);
    bus.valid_in = 1'b1;
    tick(1);
    bus.valid_in = 1'b0;
    checks++;
    if ({cs_n, mosi, bus.ready_out} !== 3'b000) begin
      errors++;
      $display("FAIL basic_accept: cs_n/mosi/ready got %b expected 000", {cs_n, mosi, bus.ready_out});
    end
    tick(111);
    checks++;
    if ({done, cs_n} !== 2'b11) begin
      errors++;
      $display("FAIL basic_done_edge: done/cs_n got %b expected 11", {done, cs_n});
    end
    tick(1);
    checks++;
    if ({done, bus.ready_out} !== 2'b00) begin
      errors++;
      $display("FAIL basic_done_pulse: done/ready got %b expected 00", {done, bus.ready_out});
    end
    tick(6);
    checks++;
    if (bus.ready_out !== 1'b0) begin
      errors++;
      $display("FAIL basic_ready_early: got %b expected 0", bus.ready_out);
    end
    tick(1);
    checks++;
    if (bus.ready_out !== 1'b1) begin
      errors++;
      $display("FAIL basic_ready_edge: got %b expected 1", bus.ready_out);
    end
    wait_ready(ok);
    tick(2);
    checks++;
    if (last_rx() !== 18'b01_10101010_01010101 || rx_q.size() - f0 !== 1) begin
      errors++;
      $display("FAIL basic_frame: got %b (%0d frames) expected 011010101001010101 (1 frame)",
               last_rx(), rx_q.size() - f0);
    end
    checks++;
    if (last_rise_cnt !== 18) begin
      errors++;
      $display("FAIL basic_rises: got %0d expected 18", last_rise_cnt);
    end
    checks++;
    if (done_edge - acc_edge_q[$] !== 111 || ready_edge - acc_edge_q[$] !== 119) begin
      errors++;
      $display("FAIL basic_latency: done +%0d ready +%0d expected +111 +119",
               done_edge - acc_edge_q[$], ready_edge - acc_edge_q[$]);
    end
    checks++;
    if (acc_cnt - a0 !== 1 || done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL basic_counts: accepts %0d dones %0d expected 1 1", acc_cnt - a0, done_cnt - d0);
    end
  endtask

  task automatic test_back_to_back();
    int a0, f0;
    bit ok;
    a0 = acc_cnt; f0 = rx_q.size();
    set_word(2'b10, 8'h0F, 8'hF0);
    bus.valid_in = 1'b1;
    tick(1);
    set_word(2'b11, 8'h5A, 8'hC3);
    for (int i = 0; i < 300; i++) begin
      if (acc_cnt >= a0 + 2) break;
      tick(1);
    end
    bus.valid_in = 1'b0;
    wait_ready(ok);
    tick(2);
    checks++;
    if (ok !== 1'b1 || acc_cnt - a0 !== 2) begin
      errors++;
      $display("FAIL b2b_accepts: got %0d (ready %b) expected 2 (ready 1)", acc_cnt - a0, ok);
    end
    checks++;
    if (acc_edge_q[$] - acc_edge_q[$-1] !== 120) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d expected 120", acc_edge_q[$] - acc_edge_q[$-1]);
    end
    checks++;
    if (rx_q.size() - f0 !== 2 || rx_q[$-1] !== 18'b10_00001111_11110000) begin
      errors++;
      $display("FAIL b2b_first: got %b (%0d frames) expected 100000111111110000 (2 frames)",
               rx_q[$-1], rx_q.size() - f0);
    end
    checks++;
    if (last_rx() !== 18'b11_01011010_11000011) begin
      errors++;
      $display("FAIL b2b_second: got %b expected 110101101011000011", last_rx());
    end
    checks++;
    if (last_high_run < 8) begin
      errors++;
      $display("FAIL b2b_gap: cs_n high %0d cycles expected at least 8", last_high_run);
    end
  endtask

  task automatic test_abort_high();
    int d0, f0, ab0;
    bit ok;
    d0 = done_cnt; f0 = rx_q.size(); ab0 = abort_cnt;
    set_word(2'b01, 8'hAA, 8'h55);
    bus.valid_in = 1'b1;
    tick(1);
    bus.valid_in = 1'b0;
    tick(51);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    checks++;
    if ({cs_n, aborted, spi_clk, mosi, bus.ready_out} !== 5'b11000) begin
      errors++;
      $display("FAIL abort_edge: cs_n/aborted/spi_clk/mosi/ready got %b expected 11000",
               {cs_n, aborted, spi_clk, mosi, bus.ready_out});
    end
    tick(7);
    checks++;
    if ({bus.ready_out, aborted} !== 2'b00) begin
      errors++;
      $display("FAIL abort_gap: ready/aborted got %b expected 00", {bus.ready_out, aborted});
    end
    tick(1);
    checks++;
    if (bus.ready_out !== 1'b1) begin
      errors++;
      $display("FAIL abort_ready: got %b expected 1", bus.ready_out);
    end
    wait_ready(ok);
    tick(2);
    checks++;
    if (last_rise_cnt !== 9) begin
      errors++;
      $display("FAIL abort_rises: got %0d expected 9", last_rise_cnt);
    end
    checks++;
    if (done_cnt - d0 !== 0 || abort_cnt - ab0 !== 1 || rx_q.size() - f0 !== 0) begin
      errors++;
      $display("FAIL abort_counts: done %0d aborted %0d frames %0d expected 0 1 0",
               done_cnt - d0, abort_cnt - ab0, rx_q.size() - f0);
    end
  endtask

  task automatic test_abort_ignored();
    int d0, ab0, f0;
    bit ok;
    d0 = done_cnt; ab0 = abort_cnt; f0 = rx_q.size();
    set_word(2'b10, 8'h3C, 8'h81);
    bus.valid_in = 1'b1;
    tick(1);
    bus.valid_in = 1'b0;
    tick(108);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    wait_ready(ok);
    tick(2);
    checks++;
    if (done_cnt - d0 !== 1 || abort_cnt - ab0 !== 0 || last_rx() !== 18'b10_00111100_10000001) begin
      errors++;
      $display("FAIL abort_hold: done %0d aborted %0d frame %b expected 1 0 100011110010000001",
               done_cnt - d0, abort_cnt - ab0, last_rx());
    end
    checks++;
    if (done_edge - acc_edge_q[$] !== 111) begin
      errors++;
      $display("FAIL abort_hold_latency: got +%0d expected +111", done_edge - acc_edge_q[$]);
    end
    d0 = done_cnt; ab0 = abort_cnt; f0 = rx_q.size();
    set_word(2'b00, 8'hFF, 8'h01);
    bus.valid_in = 1'b1;
    abort = 1'b1;
    tick(1);
    bus.valid_in = 1'b0;
    abort = 1'b0;
    checks++;
    if ({cs_n, aborted, bus.ready_out} !== 3'b000) begin
      errors++;
      $display("FAIL abort_idle_accept: cs_n/aborted/ready got %b expected 000",
               {cs_n, aborted, bus.ready_out});
    end
    wait_ready(ok);
    tick(2);
    checks++;
    if (rx_q.size() - f0 !== 1 || last_rx() !== 18'b00_11111111_00000001 || abort_cnt - ab0 !== 0) begin
      errors++;
      $display("FAIL abort_idle_frame: frame %b (%0d frames, %0d aborts) expected 001111111100000001 (1, 0)",
               last_rx(), rx_q.size() - f0, abort_cnt - ab0);
    end
  endtask

  task automatic test_reset_mid();
    int d0, ab0, f0;
    bit ok;
    d0 = done_cnt; ab0 = abort_cnt; f0 = rx_q.size();
    set_word(2'b11, 8'hFF, 8'hFF);
    bus.valid_in = 1'b1;
    tick(1);
    bus.valid_in = 1'b0;
    tick(40);
    checks++;
    if ({cs_n, mosi} !== 2'b01) begin
      errors++;
      $display("FAIL midreset_pre: cs_n/mosi got %b expected 01", {cs_n, mosi});
    end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++;
    if ({cs_n, spi_clk, mosi, bus.ready_out, done, aborted} !== 6'b100100) begin
      errors++;
      $display("FAIL midreset_edge: cs_n/spi_clk/mosi/ready/done/aborted got %b expected 100100",
               {cs_n, spi_clk, mosi, bus.ready_out, done, aborted});
    end
    tick(20);
    checks++;
    if (done_cnt - d0 !== 0 || abort_cnt - ab0 !== 0 || rx_q.size() - f0 !== 0) begin
      errors++;
      $display("FAIL midreset_pulses: done %0d aborted %0d frames %0d expected 0 0 0",
               done_cnt - d0, abort_cnt - ab0, rx_q.size() - f0);
    end
    set_word(2'b01, 8'hAA, 8'h55);
    bus.valid_in = 1'b1;
    tick(1);
    bus.valid_in = 1'b0;
    wait_ready(ok);
    tick(2);
    checks++;
    if (rx_q.size() - f0 !== 1 || last_rx() !== 18'b01_10101010_01010101) begin
      errors++;
      $display("FAIL midreset_next: frame %b (%0d frames) expected 011010101001010101 (1)",
               last_rx(), rx_q.size() - f0);
    end
  endtask

  task automatic test_busy_inputs();
    int a0, f0;
    bit ok;
    a0 = acc_cnt; f0 = rx_q.size();
    set_word(2'b01, 8'hC3, 8'h3C);
    bus.valid_in = 1'b1;
    tick(1);
    for (int i = 0; i < 90; i++) begin
      bus.opcode    = 2'(i);
      bus.key_addr  = 8'(i * 7);
      bus.text_addr = 8'(255 - i);
      bus.valid_in  = i[0];
      tick(1);
    end
    bus.valid_in = 1'b0;
    wait_ready(ok);
    tick(2);
    checks++;
    if (acc_cnt - a0 !== 1 || rx_q.size() - f0 !== 1) begin
      errors++;
      $display("FAIL busy_count: accepts %0d frames %0d expected 1 1", acc_cnt - a0, rx_q.size() - f0);
    end
    checks++;
    if (last_rx() !== 18'b01_11000011_00111100) begin
      errors++;
      $display("FAIL busy_frame: got %b expected 011100001100111100", last_rx());
    end
  endtask

  initial begin
    bus.valid_in = 1'b0;
    set_word(2'b00, 8'h00, 8'h00);
    test_reset();
    test_basic();
    test_back_to_back();
    test_abort_high();
    test_abort_ignored();
    test_reset_mid();
    test_busy_inputs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
